// File: rtl/edge_event_arbiter.sv
// Rising-edge event latch with round-robin valid/ready event port and overrun flags.
// Optional EDGE_ARB_DROP_CNT_EN adds an 8-bit saturating count of discarded edges.
module edge_event_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   x,
  output logic           ev_valid,
  output logic [IDW-1:0] ev_id,
  input  logic           ev_ready,
  output logic [N-1:0]   drop,
  input  logic           drop_clr,
`ifdef EDGE_ARB_DROP_CNT_EN
  output logic [7:0]     drop_cnt,
`endif
  output logic           busy,
  output logic           dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   x_q;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   drop_q, drop_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] ev_id_q, ev_id_d;

  logic [N-1:0]   edge_det;
  logic [N-1:0]   acc_mask;
  logic [N-1:0]   drop_new;
  logic           found;
  logic [IDW-1:0] winner;

  assign edge_det = x & ~x_q;

  // Round-robin scan starting just after the last served channel.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int off = 1; off <= N; off++) begin
      idx = int'(last_q) + off;
      if (idx >= N) idx = idx - N;
      if (!found && pending_q[idx]) begin
        found  = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end

  // Handshake: an event transfers on a clk edge where ev_valid & ev_ready;
  // once raised, ev_valid and ev_id hold until that transfer happens.
  always_comb begin
    state_d  = state_q;
    ev_id_d  = ev_id_q;
    last_d   = last_q;
    acc_mask = '0;
    unique case (state_q)
      IDLE: begin
        if (|pending_q) begin
          ev_id_d = winner;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (ev_ready) begin
          acc_mask[ev_id_q] = 1'b1;
          last_d            = ev_id_q;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // An edge landing on the channel being accepted re-arms it instead of dropping.
  assign drop_new  = edge_det & pending_q & ~acc_mask;
  assign pending_d = (pending_q & ~acc_mask) | edge_det;
  assign drop_d    = (drop_clr ? '0 : drop_q) | drop_new;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      pending_q <= '0;
      drop_q    <= '0;
      last_q    <= IDW'(N - 1);
      ev_id_q   <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      last_q    <= last_d;
      ev_id_q   <= ev_id_d;
    end
  end

`ifdef EDGE_ARB_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [4:0] drop_pop;
  logic [8:0] cnt_sum;

  always_comb begin
    drop_pop = '0;
    for (int i = 0; i < N; i++) begin
      drop_pop = drop_pop + 5'(drop_new[i]);
    end
    cnt_sum    = (drop_clr ? 9'd0 : {1'b0, drop_cnt_q}) + {4'd0, drop_pop};
    drop_cnt_d = (cnt_sum > 9'd255) ? 8'd255 : cnt_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt_q <= '0;
    else      drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign ev_valid  = (state_q == OFFER);
  assign ev_id     = ev_id_q;
  assign drop      = drop_q;
  assign busy      = (|pending_q) | ev_valid;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (N=4), hand-computed expectations.
// Build with EDGE_ARB_DROP_CNT_EN defined to also cover drop_cnt.
module tb_edge_event_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   x;
  logic           ev_valid;
  logic [IDW-1:0] ev_id;
  logic           ev_ready;
  logic [N-1:0]   drop;
  logic           drop_clr;
  logic           busy;
  logic           dbg_state;
`ifdef EDGE_ARB_DROP_CNT_EN
  logic [7:0]     drop_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  edge_event_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .ev_valid  (ev_valid),
    .ev_id     (ev_id),
    .ev_ready  (ev_ready),
    .drop      (drop),
    .drop_clr  (drop_clr),
`ifdef EDGE_ARB_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock / reset: 50 ns period, first rising edge at 50 ns.
  initial begin
    clk = 1'b1;
    forever #25 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; return 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    x        = '0;
    ev_ready = 1'b0;
    drop_clr = 1'b0;
    #5 rst = 1'b0;
    #5 rst = 1'b1;
    tick();
  endtask

  task automatic check_drop_cnt(input string tag, input logic [7:0] exp);
`ifdef EDGE_ARB_DROP_CNT_EN
    check(tag, {24'd0, drop_cnt}, {24'd0, exp});
`endif
  endtask

  initial begin
    rst      = 1'b0;
    x        = '0;
    ev_ready = 1'b0;
    drop_clr = 1'b0;
    #5;
    check("rst_valid", {31'd0, ev_valid}, 32'd0);
    check("rst_id",    {30'd0, ev_id},    32'd0);
    check("rst_busy",  {31'd0, busy},     32'd0);
    check("rst_drop",  {28'd0, drop},     32'd0);
    check_drop_cnt("rst_cnt", 8'd0);
    #20 rst = 1'b1;
    tick();

    // 1. Single edge on ch0
    x = 4'b0001;
    tick();
    check("t1_valid_k", {31'd0, ev_valid}, 32'd0);
    check("t1_busy_k",  {31'd0, busy},     32'd1);
    tick();
    check("t1_valid", {31'd0, ev_valid}, 32'd1);
    check("t1_id",    {30'd0, ev_id},    32'd0);
    ev_ready = 1'b1;
    x = 4'b0000;
    tick();
    check("t1_valid_done", {31'd0, ev_valid}, 32'd0);
    check("t1_busy_done",  {31'd0, busy},     32'd0);
    ev_ready = 1'b0;

    // 2. Round-robin from reset: ids 0,1,2,3, one per 2 clocks
    apply_reset();
    x = 4'b1111;
    ev_ready = 1'b1;
    tick();
    check("t2_pend_valid", {31'd0, ev_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t2_valid%0d", k), {31'd0, ev_valid}, 32'd1);
      check($sformatf("t2_id%0d", k),    {30'd0, ev_id},    k);
      tick();
      check($sformatf("t2_gap%0d", k),   {31'd0, ev_valid}, 32'd0);
    end
    check("t2_drop", {28'd0, drop}, 32'd0);
    check("t2_busy", {31'd0, busy}, 32'd0);
    ev_ready = 1'b0;
    x = 4'b0000;
    tick();

    // 3. Backpressure on ch2, ch1 edge queued behind it
    apply_reset();
    x = 4'b0100;
    tick();
    tick();
    check("t3_valid", {31'd0, ev_valid}, 32'd1);
    check("t3_id",    {30'd0, ev_id},    32'd2);
    x = 4'b0110;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("t3_hold_v%0d", k), {31'd0, ev_valid}, 32'd1);
      check($sformatf("t3_hold_id%0d", k), {30'd0, ev_id},   32'd2);
    end
    ev_ready = 1'b1;
    tick();
    check("t3_acc_valid", {31'd0, ev_valid}, 32'd0);
    check("t3_acc_busy",  {31'd0, busy},     32'd1);
    ev_ready = 1'b0;
    tick();
    check("t3_next_valid", {31'd0, ev_valid}, 32'd1);
    check("t3_next_id",    {30'd0, ev_id},    32'd1);
    ev_ready = 1'b1;
    tick();
    check("t3_end_busy", {31'd0, busy}, 32'd0);
    check("t3_end_drop", {28'd0, drop}, 32'd0);
    ev_ready = 1'b0;

    // 4. Overrun on ch3, then drop_clr behaviour
    apply_reset();
    x = 4'b1000;
    tick();
    tick();
    check("t4_id", {30'd0, ev_id}, 32'd3);
    x = 4'b0000;
    tick();
    check("t4_nodrop", {28'd0, drop}, 32'd0);
    x = 4'b1000;
    tick();
    check("t4_drop",  {28'd0, drop},     32'd8);
    check("t4_valid", {31'd0, ev_valid}, 32'd1);
    check("t4_id2",   {30'd0, ev_id},    32'd3);
    check_drop_cnt("t4_cnt", 8'd1);
    x = 4'b0000;
    tick();
    x = 4'b1000;
    drop_clr = 1'b1;
    tick();
    check("t4_clr_race", {28'd0, drop}, 32'd8);
    check_drop_cnt("t4_cnt_race", 8'd1);
    tick();
    drop_clr = 1'b0;
    check("t4_cleared", {28'd0, drop}, 32'd0);
    check_drop_cnt("t4_cnt_clr", 8'd0);
    ev_ready = 1'b1;
    tick();
    check("t4_acc_valid", {31'd0, ev_valid}, 32'd0);
    ev_ready = 1'b0;
    tick();
    check("t4_end_busy", {31'd0, busy}, 32'd0);
    check("t4_end_drop", {28'd0, drop}, 32'd0);

    // 5. Edge on the granted channel in its accept cycle
    apply_reset();
    x = 4'b0010;
    tick();
    tick();
    check("t5_id", {30'd0, ev_id}, 32'd1);
    x = 4'b0000;
    tick();
    x = 4'b0010;
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    check("t5_drop",  {28'd0, drop},     32'd0);
    check("t5_valid", {31'd0, ev_valid}, 32'd0);
    check("t5_busy",  {31'd0, busy},     32'd1);
    tick();
    check("t5_reoffer_v",  {31'd0, ev_valid}, 32'd1);
    check("t5_reoffer_id", {30'd0, ev_id},    32'd1);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    check("t5_end_busy", {31'd0, busy}, 32'd0);

    // 6. Reset asserted mid-OFFER with a drop recorded
    x = 4'b0001;
    tick();
    tick();
    x = 4'b0000;
    tick();
    x = 4'b0001;
    tick();
    check("t6_pre_valid", {31'd0, ev_valid}, 32'd1);
    check("t6_pre_drop",  {28'd0, drop},     32'd1);
    #5 rst = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, ev_valid}, 32'd0);
    check("t6_rst_busy",  {31'd0, busy},     32'd0);
    check("t6_rst_drop",  {28'd0, drop},     32'd0);
    check_drop_cnt("t6_rst_cnt", 8'd0);
    #5 rst = 1'b1;
    tick();
    check("t6_rel_busy",  {31'd0, busy},     32'd1);
    check("t6_rel_valid", {31'd0, ev_valid}, 32'd0);
    tick();
    check("t6_new_valid", {31'd0, ev_valid}, 32'd1);
    check("t6_new_id",    {30'd0, ev_id},    32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
